// File: rtl/exibidor_soma.sv
`default_nettype none
// ============================================================================
//  Module      : exibidor_soma
//  Description : Captures each new result of the summation state machine,
//                converts the signed 6-bit sum to sign + two BCD digits with
//                an iterative double-dabble engine and drives three 7-segment
//                displays (sign, tens, units). One result can be held pending
//                while a conversion is in progress.
//  Revision    : 1.0 - initial release
// ============================================================================
module exibidor_soma #(
  parameter bit ATIVO_BAIXO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pronto,
  input  logic [5:0] soma,
  input  logic       overflow,
  output logic [6:0] hex_sinal,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic [3:0] dezenas,
  output logic [3:0] unidades,
  output logic       ocupado,
  output logic       valido
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    ATUALIZA = 2'd2
  } estado_t;

  // Active-high segment codes, gfedcba with bit0 = a
  localparam logic [6:0] c_traco   = 7'b1000000;
  localparam logic [6:0] c_branco  = 7'b0000000;
  localparam logic [6:0] c_mascara = ATIVO_BAIXO ? 7'b1111111 : 7'b0000000;

  estado_t     r_estado;
  estado_t     w_prox;
  logic        r_pronto_d;
  logic        r_pendente;
  logic [5:0]  r_hold_soma;
  logic        r_hold_ovf;
  logic [5:0]  r_mag;
  logic [3:0]  r_dez;
  logic [3:0]  r_uni;
  logic [2:0]  r_cont;
  logic        r_sinal;
  logic        r_ovf;

  logic        w_borda;
  logic        w_carrega;
  logic [5:0]  w_src_soma;
  logic        w_src_ovf;
  logic [5:0]  w_src_mag;
  logic [3:0]  w_dez_aj;
  logic [3:0]  w_uni_aj;
  logic [13:0] w_desloc;
  logic [6:0]  w_seg_sinal;
  logic [6:0]  w_seg_dez;
  logic [6:0]  w_seg_uni;

  function automatic logic [6:0] seg7(input logic [3:0] digito);
    case (digito)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // A new result is a rising edge of pronto; reset value 1 masks power-up pronto
  assign w_borda   = pronto & ~r_pronto_d;
  assign w_carrega = (r_estado == OCIOSO) && (r_pendente || w_borda);

  // Pending result has priority over a direct capture from the inputs
  assign w_src_soma = r_pendente ? r_hold_soma : soma;
  assign w_src_ovf  = r_pendente ? r_hold_ovf  : overflow;
  assign w_src_mag  = w_src_soma[5] ? (~w_src_soma + 6'd1) : w_src_soma;

  // Double-dabble step: correct nibbles >= 5, then shift left by one
  assign w_dez_aj = (r_dez >= 4'd5) ? r_dez + 4'd3 : r_dez;
  assign w_uni_aj = (r_uni >= 4'd5) ? r_uni + 4'd3 : r_uni;
  assign w_desloc = {w_dez_aj, w_uni_aj, r_mag} << 1;

  // Overflow overrides every display with a dash
  assign w_seg_sinal = (r_ovf || r_sinal) ? c_traco : c_branco;
  assign w_seg_dez   = r_ovf ? c_traco : ((r_dez == 4'd0) ? c_branco : seg7(r_dez));
  assign w_seg_uni   = r_ovf ? c_traco : seg7(r_uni);

  assign ocupado = (r_estado != OCIOSO);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_estado <= OCIOSO;
    else       r_estado <= w_prox;
  end

  // Next-state logic
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:   if (r_pendente || w_borda) w_prox = CONVERTE;
      CONVERTE: if (r_cont == 3'd0)        w_prox = ATUALIZA;
      ATUALIZA: w_prox = OCIOSO;
      default:  w_prox = OCIOSO;
    endcase
  end

  // Edge detector and single-entry hold register; latest edge wins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pronto_d  <= 1'b1;
      r_pendente  <= 1'b0;
      r_hold_soma <= 6'd0;
      r_hold_ovf  <= 1'b0;
    end else begin
      r_pronto_d <= pronto;
      if (w_borda && ((r_estado != OCIOSO) || r_pendente)) begin
        r_hold_soma <= soma;
        r_hold_ovf  <= overflow;
        r_pendente  <= 1'b1;
      end else if (w_carrega) begin
        r_pendente <= 1'b0;
      end
    end
  end

  // Conversion engine: load on capture, six shift-add-3 steps while converting
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mag   <= 6'd0;
      r_dez   <= 4'd0;
      r_uni   <= 4'd0;
      r_cont  <= 3'd0;
      r_sinal <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_carrega) begin
      r_mag   <= w_src_mag;
      r_dez   <= 4'd0;
      r_uni   <= 4'd0;
      r_cont  <= 3'd5;
      r_sinal <= w_src_soma[5];
      r_ovf   <= w_src_ovf;
    end else if (r_estado == CONVERTE) begin
      r_dez  <= w_desloc[13:10];
      r_uni  <= w_desloc[9:6];
      r_mag  <= w_desloc[5:0];
      r_cont <= r_cont - 3'd1;
    end
  end

  // Output registers updated once per finished conversion
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_sinal <= c_branco ^ c_mascara;
      hex1      <= c_branco ^ c_mascara;
      hex0      <= c_branco ^ c_mascara;
      dezenas   <= 4'd0;
      unidades  <= 4'd0;
      valido    <= 1'b0;
    end else begin
      valido <= (r_estado == ATUALIZA);
      if (r_estado == ATUALIZA) begin
        hex_sinal <= w_seg_sinal ^ c_mascara;
        hex1      <= w_seg_dez   ^ c_mascara;
        hex0      <= w_seg_uni   ^ c_mascara;
        dezenas   <= r_dez;
        unidades  <= r_uni;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exibidor_soma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exibidor_soma
//  Description : Directed self-checking bench for exibidor_soma (active-low
//                segments). Inputs change 1 ns after a rising edge and outputs
//                are sampled at the same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exibidor_soma;

  logic       clk = 1'b0;
  logic       reset;
  logic       pronto;
  logic [5:0] soma;
  logic       overflow;
  logic [6:0] hex_sinal, hex1, hex0;
  logic [3:0] dezenas, unidades;
  logic       ocupado, valido;

  int total = 0;
  int bad   = 0;

  // Active-low display codes
  localparam logic [6:0] c_blank = 7'b1111111;
  localparam logic [6:0] c_dash  = 7'b0111111;
  localparam logic [6:0] c_d0    = 7'b1000000;
  localparam logic [6:0] c_d1    = 7'b1111001;
  localparam logic [6:0] c_d2    = 7'b0100100;
  localparam logic [6:0] c_d3    = 7'b0110000;
  localparam logic [6:0] c_d4    = 7'b0011001;
  localparam logic [6:0] c_d5    = 7'b0010010;
  localparam logic [6:0] c_d7    = 7'b1111000;
  localparam logic [6:0] c_d9    = 7'b0010000;

  exibidor_soma #(.ATIVO_BAIXO(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .pronto    (pronto),
    .soma      (soma),
    .overflow  (overflow),
    .hex_sinal (hex_sinal),
    .hex1      (hex1),
    .hex0      (hex0),
    .dezenas   (dezenas),
    .unidades  (unidades),
    .ocupado   (ocupado),
    .valido    (valido)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Produce a 0->1 on pronto; returns just after edge E
  task automatic do_edge(input logic [5:0] s, input logic ov);
    pronto = 1'b0;
    tick();
    soma     = s;
    overflow = ov;
    pronto   = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; pronto = 1'b1; soma = 6'd0; overflow = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (ocupado !== 1'b0 || valido !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d ocupado=%b valido=%b want 0/0", i, ocupado, valido);
      end
    end
    total++;
    if (hex_sinal !== c_blank || hex1 !== c_blank || hex0 !== c_blank) begin
      bad++;
      $display("FAIL reset_hex got %b %b %b want all 1111111", hex_sinal, hex1, hex0);
    end
    total++;
    if (dezenas !== 4'd0 || unidades !== 4'd0) begin
      bad++;
      $display("FAIL reset_bcd got %0d %0d want 0 0", dezenas, unidades);
    end
  endtask

  task automatic test_conversions();
    logic [5:0] t_s   [7];
    logic       t_ov  [7];
    logic [6:0] t_hs  [7];
    logic [6:0] t_h1  [7];
    logic [6:0] t_h0  [7];
    logic [3:0] t_d   [7];
    logic [3:0] t_u   [7];
    logic [6:0] prev_h0;
    t_s[0]=6'd23;       t_ov[0]=0; t_hs[0]=c_blank; t_h1[0]=c_d2;    t_h0[0]=c_d3;  t_d[0]=2; t_u[0]=3;
    t_s[1]=6'b100000;   t_ov[1]=0; t_hs[1]=c_dash;  t_h1[1]=c_d3;    t_h0[1]=c_d2;  t_d[1]=3; t_u[1]=2;
    t_s[2]=6'd5;        t_ov[2]=0; t_hs[2]=c_blank; t_h1[2]=c_blank; t_h0[2]=c_d5;  t_d[2]=0; t_u[2]=5;
    t_s[3]=6'd0;        t_ov[3]=0; t_hs[3]=c_blank; t_h1[3]=c_blank; t_h0[3]=c_d0;  t_d[3]=0; t_u[3]=0;
    t_s[4]=6'b101000;   t_ov[4]=1; t_hs[4]=c_dash;  t_h1[4]=c_dash;  t_h0[4]=c_dash; t_d[4]=2; t_u[4]=4;
    t_s[5]=6'b111111;   t_ov[5]=0; t_hs[5]=c_dash;  t_h1[5]=c_blank; t_h0[5]=c_d1;  t_d[5]=0; t_u[5]=1;
    t_s[6]=6'd31;       t_ov[6]=0; t_hs[6]=c_blank; t_h1[6]=c_d3;    t_h0[6]=c_d1;  t_d[6]=3; t_u[6]=1;
    prev_h0 = c_blank;
    for (int v = 0; v < 7; v++) begin
      do_edge(t_s[v], t_ov[v]);
      for (int k = 0; k < 7; k++) begin
        total++;
        if (ocupado !== 1'b1 || valido !== 1'b0 || hex0 !== prev_h0) begin
          bad++;
          $display("FAIL conv%0d_busy E+%0d ocupado=%b valido=%b hex0=%b want 1/0/%b",
                   v, k, ocupado, valido, hex0, prev_h0);
        end
        tick();
      end
      total++;
      if (valido !== 1'b1 || ocupado !== 1'b0) begin
        bad++;
        $display("FAIL conv%0d_done valido=%b ocupado=%b want 1/0", v, valido, ocupado);
      end
      total++;
      if (hex_sinal !== t_hs[v] || hex1 !== t_h1[v] || hex0 !== t_h0[v]) begin
        bad++;
        $display("FAIL conv%0d_hex got %b %b %b want %b %b %b",
                 v, hex_sinal, hex1, hex0, t_hs[v], t_h1[v], t_h0[v]);
      end
      total++;
      if (dezenas !== t_d[v] || unidades !== t_u[v]) begin
        bad++;
        $display("FAIL conv%0d_bcd got %0d%0d want %0d%0d", v, dezenas, unidades, t_d[v], t_u[v]);
      end
      // pronto stays high: no second capture and valido drops
      for (int k = 0; k < 8; k++) begin
        tick();
        total++;
        if (valido !== 1'b0 || ocupado !== 1'b0) begin
          bad++;
          $display("FAIL conv%0d_hold E+%0d valido=%b ocupado=%b want 0/0", v, k + 8, valido, ocupado);
        end
      end
      prev_h0 = t_h0[v];
    end
  endtask

  task automatic test_back_to_back();
    do_edge(6'd7, 1'b0);           // edge E
    tick();                        // E+1
    pronto = 1'b0;
    tick();                        // E+2
    soma = 6'b110111; pronto = 1'b1;
    tick();                        // E+3: second edge while busy
    for (int n = 4; n <= 17; n++) begin
      tick();
      total++;
      if (valido !== ((n == 7 || n == 15) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL b2b_valido E+%0d got %b", n, valido);
      end
      if (n == 7 || n == 14) begin
        total++;
        if (hex0 !== c_d7 || hex_sinal !== c_blank || hex1 !== c_blank) begin
          bad++;
          $display("FAIL b2b_first E+%0d got %b %b %b want %b %b %b",
                   n, hex_sinal, hex1, hex0, c_blank, c_blank, c_d7);
        end
      end
      if (n == 15) begin
        total++;
        if (hex0 !== c_d9 || hex_sinal !== c_dash || hex1 !== c_blank || unidades !== 4'd9) begin
          bad++;
          $display("FAIL b2b_second got %b %b %b u=%0d want %b %b %b u=9",
                   hex_sinal, hex1, hex0, unidades, c_dash, c_blank, c_d9);
        end
      end
    end
  endtask

  task automatic test_overwrite();
    do_edge(6'd1, 1'b0);           // E
    pronto = 1'b0; tick();         // E+1
    soma = 6'd2; pronto = 1'b1; tick();   // E+2 edge
    pronto = 1'b0; tick();         // E+3
    soma = 6'd4; pronto = 1'b1; tick();   // E+4 edge, overwrites hold
    for (int n = 5; n <= 15; n++) begin
      tick();
      if (n == 7) begin
        total++;
        if (hex0 !== c_d1 || valido !== 1'b1) begin
          bad++;
          $display("FAIL ovw_first got hex0=%b valido=%b want %b/1", hex0, valido, c_d1);
        end
      end
      if (n == 15) begin
        total++;
        if (hex0 !== c_d4 || valido !== 1'b1 || unidades !== 4'd4) begin
          bad++;
          $display("FAIL ovw_latest got hex0=%b valido=%b u=%0d want %b/1/4", hex0, valido, unidades, c_d4);
        end
      end
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      total++;
      if (ocupado !== 1'b0) begin
        bad++;
        $display("FAIL ovw_single_pending cyc=%0d ocupado=%b want 0", n, ocupado);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_edge(6'd12, 1'b0);          // E
    tick(); tick();                // E+2
    reset = 1'b1;
    tick();                        // E+3 reset sampled
    reset = 1'b0;
    total++;
    if (hex_sinal !== c_blank || hex1 !== c_blank || hex0 !== c_blank || dezenas !== 4'd0) begin
      bad++;
      $display("FAIL rstmid_blank got %b %b %b d=%0d want blank d=0", hex_sinal, hex1, hex0, dezenas);
    end
    for (int n = 0; n < 12; n++) begin
      tick();
      total++;
      if (valido !== 1'b0 || ocupado !== 1'b0 || hex0 !== c_blank) begin
        bad++;
        $display("FAIL rstmid_quiet cyc=%0d valido=%b ocupado=%b hex0=%b want 0/0/blank",
                 n, valido, ocupado, hex0);
      end
    end
    do_edge(6'd12, 1'b0);
    for (int k = 0; k < 7; k++) tick();
    total++;
    if (valido !== 1'b1 || hex1 !== c_d1 || hex0 !== c_d2 || dezenas !== 4'd1 || unidades !== 4'd2) begin
      bad++;
      $display("FAIL rstmid_after got v=%b %b %b %0d%0d want 1 %b %b 12",
               valido, hex1, hex0, dezenas, unidades, c_d1, c_d2);
    end
  endtask

  initial begin
    reset = 1'b1; pronto = 1'b1; soma = 6'd0; overflow = 1'b0;
    test_reset();
    test_conversions();
    test_back_to_back();
    test_overwrite();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
